// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline hazard controller and its requesters / pipeline stages.
// The master side drives stall requests and redirects; the slave side (the controller) answers.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned NSTAGE = 6,
  parameter int unsigned NREQ   = 2,
  parameter int unsigned CNTW   = 6
);
  logic [NREQ-1:0]   stallreq;
  logic              mc_start;
  logic [CNTW-1:0]   mc_len;
  logic              excp_req;
  logic [31:0]       excp_pc;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_busy;
  logic [31:0]       stall_cnt;

  modport master (
    output stallreq, mc_start, mc_len, excp_req, excp_pc,
    input  stall, flush, new_pc, mc_busy, stall_cnt
  );

  modport slave (
    input  stallreq, mc_start, mc_len, excp_req, excp_pc,
    output stall, flush, new_pc, mc_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: merges single-cycle stall requests and a fixed-latency multi-cycle
// engine into a per-stage stall mask, and turns exceptions into a one-cycle flush with redirect.
module pipe_hazard_ctrl #(
  parameter int unsigned            NSTAGE    = 6,
  parameter int unsigned            NREQ      = 2,
  parameter logic [4*NREQ-1:0]      DEPTH_VEC = {4'd3, 4'd2},
  parameter int unsigned            MC_DEPTH  = 3,
  parameter int unsigned            CNTW      = 6
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMcBusy, StFlush} state_e;

  state_e            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic              flush_q;
  logic              mc_busy_q;
  logic [31:0]       new_pc_q;
  logic [31:0]       stall_cnt_q;
  logic [NSTAGE-1:0] stall;
  logic              mc_start_ok;
  logic              mc_active;

  // Bits 0..d set; any depth past the last stage naturally saturates to all ones.
  function automatic logic [NSTAGE-1:0] depth_mask(input int unsigned d);
    logic [NSTAGE-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      m[k] = (k <= d);
    end
    return m;
  endfunction

  // An exception in the same cycle cancels the start, so it never contributes a stall.
  assign mc_start_ok = (state_q == StIdle) && bus.mc_start && !bus.excp_req &&
                       (bus.mc_len != '0);
  assign mc_active   = (state_q == StMcBusy) || mc_start_ok;

  always_comb begin
    stall = '0;
    if (!rst && !flush_q) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.stallreq[i]) begin
          stall = stall | depth_mask({28'd0, DEPTH_VEC[4*i +: 4]});
        end
      end
      if (mc_active) begin
        stall = stall | depth_mask(MC_DEPTH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      mc_busy_q   <= 1'b0;
      new_pc_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end

      if (bus.excp_req) begin
        state_q   <= StFlush;
        flush_q   <= 1'b1;
        new_pc_q  <= bus.excp_pc;
        cnt_q     <= '0;
        mc_busy_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            flush_q <= 1'b0;
            // Length 1 is covered entirely by the start-cycle stall; no busy phase.
            if (bus.mc_start && (bus.mc_len >= CNTW'(2))) begin
              cnt_q     <= bus.mc_len - CNTW'(1);
              state_q   <= StMcBusy;
              mc_busy_q <= 1'b1;
            end
          end
          StMcBusy: begin
            if (cnt_q <= CNTW'(1)) begin
              cnt_q     <= '0;
              state_q   <= StIdle;
              mc_busy_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          StFlush: begin
            state_q <= StIdle;
            flush_q <= 1'b0;
          end
          default: begin
            state_q   <= StIdle;
            flush_q   <= 1'b0;
            mc_busy_q <= 1'b0;
            cnt_q     <= '0;
          end
        endcase
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush_q;
  assign bus.new_pc    = new_pc_q;
  assign bus.mc_busy   = mc_busy_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-by-cycle vector table plus hand-written
// sequences for reset during a multi-cycle op and stall counter saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGE(6), .NREQ(2), .CNTW(6)) hz ();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (hz)
  );

  typedef struct {
    logic [1:0]  sr;
    logic        st;
    logic [5:0]  len;
    logic        ex;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic [1:0] sr, input logic st, input logic [5:0] len,
                              input logic ex, input logic [31:0] pc, input logic [5:0] es,
                              input logic ef, input logic [31:0] ep, input logic eb);
    vec_t v;
    v.sr = sr; v.st = st; v.len = len; v.ex = ex; v.pc = pc;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sr, input logic st, input logic [5:0] len,
                       input logic ex, input logic [31:0] pc);
    hz.stallreq = sr;
    hz.mc_start = st;
    hz.mc_len   = len;
    hz.excp_req = ex;
    hz.excp_pc  = pc;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b11, 1'b1, 6'd4, 1'b1, 32'h1234);
    // Cycle-by-cycle expectations; registered outputs reflect earlier rows.
    vecs[0]  = mk(2'b01, 0, 6'd0, 0, 32'h0,        6'b000111, 0, 32'h0,        0);
    vecs[1]  = mk(2'b10, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0);
    vecs[2]  = mk(2'b11, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        0);
    vecs[3]  = mk(2'b00, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
    vecs[4]  = mk(2'b00, 1, 6'd4, 0, 32'h0,        6'b001111, 0, 32'h0,        0);
    vecs[5]  = mk(2'b00, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        1);
    vecs[6]  = mk(2'b00, 1, 6'd9, 0, 32'h0,        6'b001111, 0, 32'h0,        1);
    vecs[7]  = mk(2'b00, 0, 6'd0, 0, 32'h0,        6'b001111, 0, 32'h0,        1);
    vecs[8]  = mk(2'b00, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
    vecs[9]  = mk(2'b00, 1, 6'd4, 0, 32'h0,        6'b001111, 0, 32'h0,        0);
    vecs[10] = mk(2'b00, 0, 6'd0, 1, 32'hBFC00380, 6'b001111, 0, 32'h0,        1);
    vecs[11] = mk(2'b11, 0, 6'd0, 0, 32'h0,        6'b000000, 1, 32'hBFC00380, 0);
    vecs[12] = mk(2'b01, 0, 6'd0, 0, 32'h0,        6'b000111, 0, 32'hBFC00380, 0);
    vecs[13] = mk(2'b01, 1, 6'd4, 1, 32'h1000,     6'b000111, 0, 32'hBFC00380, 0);
    vecs[14] = mk(2'b01, 0, 6'd0, 1, 32'h2000,     6'b000000, 1, 32'h1000,     0);
    vecs[15] = mk(2'b01, 0, 6'd0, 0, 32'h0,        6'b000000, 1, 32'h2000,     0);
    vecs[16] = mk(2'b00, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h2000,     0);
    vecs[17] = mk(2'b00, 1, 6'd1, 0, 32'h0,        6'b001111, 0, 32'h2000,     0);
    vecs[18] = mk(2'b00, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h2000,     0);
    vecs[19] = mk(2'b00, 1, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h2000,     0);
    vecs[20] = mk(2'b00, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 32'h2000,     0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst stall", 32'(hz.stall), 32'h0);
    chk("rst flush", 32'(hz.flush), 32'h0);
    chk("rst new_pc", hz.new_pc, 32'h0);
    chk("rst mc_busy", 32'(hz.mc_busy), 32'h0);
    chk("rst stall_cnt", hz.stall_cnt, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 1'b0, 6'd0, 1'b0, 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].sr, vecs[i].st, vecs[i].len, vecs[i].ex, vecs[i].pc);
      #1;
      chk($sformatf("row%0d stall", i), 32'(hz.stall), 32'(vecs[i].e_stall));
      chk($sformatf("row%0d flush", i), 32'(hz.flush), 32'(vecs[i].e_flush));
      chk($sformatf("row%0d new_pc", i), hz.new_pc, vecs[i].e_pc);
      chk($sformatf("row%0d mc_busy", i), 32'(hz.mc_busy), 32'(vecs[i].e_busy));
    end
    @(negedge clk);
    drive(2'b00, 1'b0, 6'd0, 1'b0, 32'h0);
    #1;
    chk("table stall_cnt", hz.stall_cnt, 32'd12);

    // Reset in the middle of a multi-cycle op, with competing requests.
    @(negedge clk);
    drive(2'b00, 1'b1, 6'd6, 1'b0, 32'h0);
    @(negedge clk);
    drive(2'b00, 1'b0, 6'd0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk("pre-rst mc_busy", 32'(hz.mc_busy), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b01, 1'b1, 6'd5, 1'b1, 32'hDEAD0000);
    #1;
    chk("in-rst stall", 32'(hz.stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 1'b0, 6'd0, 1'b0, 32'h0);
    #1;
    chk("post-rst stall", 32'(hz.stall), 32'h0);
    chk("post-rst flush", 32'(hz.flush), 32'h0);
    chk("post-rst new_pc", hz.new_pc, 32'h0);
    chk("post-rst mc_busy", 32'(hz.mc_busy), 32'h0);
    chk("post-rst stall_cnt", hz.stall_cnt, 32'h0);

    // Four-cycle op from a clean counter.
    @(negedge clk);
    drive(2'b00, 1'b1, 6'd4, 1'b0, 32'h0);
    #1;
    chk("mc4 T stall", 32'(hz.stall), 32'h0F);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(2'b00, 1'b0, 6'd0, 1'b0, 32'h0);
      #1;
      chk($sformatf("mc4 T+%0d stall", k), 32'(hz.stall), 32'h0F);
      chk($sformatf("mc4 T+%0d mc_busy", k), 32'(hz.mc_busy), 32'h1);
    end
    @(negedge clk);
    #1;
    chk("mc4 T+4 stall", 32'(hz.stall), 32'h0);
    chk("mc4 T+4 mc_busy", 32'(hz.mc_busy), 32'h0);
    chk("mc4 stall_cnt", hz.stall_cnt, 32'd4);

    // Preload the counter just below its ceiling and keep stalling.
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFC;
    drive(2'b01, 1'b0, 6'd0, 1'b0, 32'h0);
    #1;
    release dut.stall_cnt_q;
    repeat (2) @(negedge clk);
    #1;
    chk("sat +2", hz.stall_cnt, 32'hFFFF_FFFE);
    @(negedge clk);
    #1;
    chk("sat +3", hz.stall_cnt, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    #1;
    chk("sat +6", hz.stall_cnt, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NSTAGE, default 6, width of stall bus; bit 0 = PC, bit k = pipeline stage k.
REQ-002 Parameter NREQ, default 2, number of single-cycle stall request sources.
REQ-003 Parameter DEPTH_VEC, default {4'd3,4'd2}, packed 4-bit depth per source (source i at bits [4i+3:4i]); source 0 = load-use, source 1 = EX.
REQ-004 Parameter MC_DEPTH, default 3, stall depth used by the multi-cycle engine.
REQ-005 Parameter CNTW, default 6, width of multi-cycle length field.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 stallreq  in  NREQ  per-source stall request, level, sampled every cycle.
REQ-009 mc_start  in  1  start of fixed-latency multi-cycle operation.
REQ-010 mc_len  in  CNTW  total stall cycles for that operation, valid with mc_start.
REQ-011 excp_req  in  1  exception/redirect request.
REQ-012 excp_pc  in  32  redirect target, valid with excp_req.
REQ-013 stall  out  NSTAGE  per-stage stall, combinational.
REQ-014 flush  out  1  registered one-cycle flush pulse.
REQ-015 new_pc  out  32  registered redirect target, valid while flush=1.
REQ-016 mc_busy  out  1  high while multi-cycle engine holds stall beyond its start cycle.
REQ-017 stall_cnt  out  32  count of cycles with stall[0]=1.

Function
REQ-018 Depth d SHALL map to mask with bits 0..d set, all higher bits clear (d=2 -> 000111, d=3 -> 001111 at NSTAGE=6); d >= NSTAGE-1 saturates to all ones.
REQ-019 stall SHALL be bitwise OR of masks of all asserted stallreq bits, plus MC_DEPTH mask when multi-cycle stall is active.
REQ-020 State machine SHALL have states IDLE, MC_BUSY, FLUSH.
REQ-021 IDLE, mc_start=1, mc_len=N>=2, excp_req=0: MC mask applied in start cycle, counter loads N-1, next state MC_BUSY.
REQ-022 IDLE, mc_start=1 with mc_len=1: MC mask applied in start cycle only, remain IDLE; mc_len=0: no MC stall, remain IDLE.
REQ-023 MC_BUSY: MC mask applied and mc_busy=1 every cycle; counter decrements each cycle; on counter reaching 1 -> IDLE next cycle (total stall = N cycles including start).
REQ-024 mc_start SHALL be ignored in MC_BUSY and FLUSH.
REQ-025 excp_req=1 in any state SHALL, next cycle, enter FLUSH, set flush=1, latch new_pc=excp_pc, clear counter; pending multi-cycle op abandoned.
REQ-026 excp_req has priority over simultaneous mc_start (mc_start dropped).
REQ-027 FLUSH lasts one cycle, then IDLE; excp_req during FLUSH re-enters FLUSH with new excp_pc (flush stays high).
REQ-028 While flush=1, stall SHALL be forced to all zeros regardless of stallreq.
REQ-029 new_pc SHALL hold its last value when flush=0.
REQ-030 stall_cnt increments by 1 each cycle stall[0]=1, saturates at 32'hFFFFFFFF.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, counter 0, flush 0, new_pc 0, mc_busy 0, stall_cnt 0.
REQ-032 While rst=1, stall SHALL be all zeros; rst overrides excp_req and mc_start in the same cycle, including mid-MC_BUSY or FLUSH.

Verification
REQ-033 Defaults; stallreq=01 -> stall=000111; stallreq=10 -> 001111; stallreq=11 -> 001111; stallreq=00 -> 000000.
REQ-034 mc_start=1, mc_len=4 at cycle T -> stall=001111 cycles T..T+3, mc_busy=1 cycles T+1..T+3, stall=0 at T+4; stall_cnt=4.
REQ-035 mc_len=4 started, excp_req=1, excp_pc=32'hBFC00380 at T+1 -> flush=1, new_pc=32'hBFC00380, stall=0 at T+2, mc_busy=0 from T+2, IDLE at T+3.
REQ-036 mc_start and excp_req same cycle with stallreq=01 -> that cycle stall=000111, next cycle flush=1 and stall=0, no MC stall ever.
REQ-037 rst asserted during MC_BUSY -> next cycle all outputs zero, stall_cnt=0; mc_len=0 and mc_len=1 starts -> 0 and 1 stall cycles.
REQ-038 Force stall_cnt near max (hold stallreq=01 or preload via long run) -> count stops at 32'hFFFFFFFF, no wrap.
